// File: rtl/ones_ctrl_pkg.sv
// Shared types and reset defaults for the ones_window_ctrl block.
package ones_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } ones_state_t;

    localparam int DEF_THRESH = 4;
    localparam int DEF_WINDOW = 0;

endpackage

// File: rtl/ones_window_ctrl_if.sv
// Config, job-control, sample and status signals of ones_window_ctrl.
interface ones_window_ctrl_if #(
    parameter int CNT_W = 4,
    parameter int WIN_W = 8
);
    logic             cfg_we;
    logic [CNT_W-1:0] cfg_thresh;
    logic [WIN_W-1:0] cfg_window;
    logic             start;
    logic             abort;
    logic             data;
    logic             busy;
    logic             done;
    logic             flag;
    logic             timeout;
    logic [CNT_W-1:0] hit_count;

    modport master (
        output cfg_we, cfg_thresh, cfg_window, start, abort, data,
        input  busy, done, flag, timeout, hit_count
    );

    modport slave (
        input  cfg_we, cfg_thresh, cfg_window, start, abort, data,
        output busy, done, flag, timeout, hit_count
    );
endinterface

// File: rtl/ones_counter.sv
// Loadable saturating up-counter; eq compares the value it will take on
// this edge against cmp_val, so callers can react in the same cycle.
module ones_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] cmp_val,
    output logic [W-1:0] count,
    output logic         eq
);
    logic [W-1:0] count_nxt_s;

    // Next value, holding at all-ones instead of wrapping.
    always_comb begin
        count_nxt_s = count;
        if (inc && (count != {W{1'b1}})) begin
            count_nxt_s = count + W'(1);
        end else begin
            count_nxt_s = count;
        end
        eq = (count_nxt_s == cmp_val);
    end

    // Count register; load takes priority over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= {W{1'b0}};
        end else if (load) begin
            count <= load_val;
        end else begin
            count <= count_nxt_s;
        end
    end
endmodule

// File: rtl/ones_window_ctrl.sv
// Start/done job controller: counts ones on the serial input until a
// threshold is reached (hit) or the observation window runs out (timeout).
module ones_window_ctrl
    import ones_ctrl_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int WIN_W      = 8,
    parameter int DEF_THRESH = ones_ctrl_pkg::DEF_THRESH
) (
    input logic               clk,
    input logic               rst,
    ones_window_ctrl_if.slave bus
);
    ones_state_t      state_r;
    ones_state_t      state_s;
    logic [CNT_W-1:0] thr_r;
    logic [WIN_W-1:0] win_r;
    logic [CNT_W-1:0] eff_thresh_s;
    logic [CNT_W-1:0] ones_r;
    logic [WIN_W-1:0] unused_elapsed_r;
    logic             ones_eq_s;
    logic             elapsed_eq_s;
    logic             job_load_s;
    logic             ones_inc_s;
    logic             elapsed_inc_s;
    logic             flag_s;
    logic             timeout_s;
    logic             flag_r;
    logic             timeout_r;

    assign eff_thresh_s = (thr_r == {CNT_W{1'b0}}) ? CNT_W'(1) : thr_r;

    ones_counter #(.W(CNT_W)) u_ones (
        .clk      (clk),
        .rst      (rst),
        .load     (job_load_s),
        .load_val ({CNT_W{1'b0}}),
        .inc      (ones_inc_s),
        .cmp_val  (eff_thresh_s),
        .count    (ones_r),
        .eq       (ones_eq_s)
    );

    ones_counter #(.W(WIN_W)) u_elapsed (
        .clk      (clk),
        .rst      (rst),
        .load     (job_load_s),
        .load_val ({WIN_W{1'b0}}),
        .inc      (elapsed_inc_s),
        .cmp_val  (win_r),
        .count    (unused_elapsed_r),
        .eq       (elapsed_eq_s)
    );

    // Next state and counter control; abort outranks hit, hit outranks expiry.
    always_comb begin
        state_s       = state_r;
        job_load_s    = 1'b0;
        ones_inc_s    = 1'b0;
        elapsed_inc_s = 1'b0;
        flag_s        = 1'b0;
        timeout_s     = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_s    = COUNT;
                    job_load_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            COUNT: begin
                if (bus.abort) begin
                    state_s = IDLE;
                end else begin
                    ones_inc_s    = bus.data;
                    elapsed_inc_s = 1'b1;
                    if (ones_eq_s) begin
                        state_s = DONE;
                        flag_s  = 1'b1;
                    end else if ((win_r != {WIN_W{1'b0}}) && elapsed_eq_s) begin
                        state_s   = DONE;
                        timeout_s = 1'b1;
                    end else begin
                        state_s = COUNT;
                    end
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and result-qualifier registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            flag_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            flag_r    <= flag_s;
            timeout_r <= timeout_s;
        end
    end

    // Config registers are frozen while a job is counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            thr_r <= CNT_W'(DEF_THRESH);
            win_r <= WIN_W'(ones_ctrl_pkg::DEF_WINDOW);
        end else if (bus.cfg_we && (state_r != COUNT)) begin
            thr_r <= bus.cfg_thresh;
            win_r <= bus.cfg_window;
        end else begin
            thr_r <= thr_r;
            win_r <= win_r;
        end
    end

    assign bus.busy      = (state_r == COUNT);
    assign bus.done      = (state_r == DONE);
    assign bus.flag      = flag_r;
    assign bus.timeout   = timeout_r;
    assign bus.hit_count = ones_r;
endmodule

// File: tb/tb_ones_window_ctrl.sv
// Directed table-driven bench for ones_window_ctrl plus a reset-mid-job sequence.
module tb_ones_window_ctrl;
    import ones_ctrl_pkg::*;

    typedef struct {
        logic       start;
        logic       abort;
        logic       cfg_we;
        logic [3:0] thr;
        logic [7:0] win;
        logic       data;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[$];

    ones_window_ctrl_if #(.CNT_W(4), .WIN_W(8)) bus ();

    ones_window_ctrl #(.CNT_W(4), .WIN_W(8), .DEF_THRESH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // ctl = {start, abort, cfg_we}; eo = {busy, done, flag, timeout}
    task automatic add(input logic [2:0] ctl, input logic [3:0] th, input logic [7:0] wi,
                       input logic d, input logic [3:0] eo, input logic [3:0] eh);
        vec_t v;
        v.start  = ctl[2];
        v.abort  = ctl[1];
        v.cfg_we = ctl[0];
        v.thr    = th;
        v.win    = wi;
        v.data   = d;
        v.exp    = {eo, eh};
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual={busy,done,flag,timeout,hit_count}=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick_check(input string nm, input logic [7:0] exp);
        @(negedge clk);
        check(nm, {bus.busy, bus.done, bus.flag, bus.timeout, bus.hit_count}, exp);
    endtask

    initial begin
        bus.cfg_we = 1'b0; bus.cfg_thresh = 4'd0; bus.cfg_window = 8'd0;
        bus.start = 1'b0;  bus.abort = 1'b0;      bus.data = 1'b0;

        // Defaults (thr=4, unlimited window), ones not consecutive
        add(3'b100, 4'd0, 8'd0, 1'b0, 4'b0000, 4'd0);
        add(3'b000, 4'd0, 8'd0, 1'b1, 4'b1000, 4'd0);
        add(3'b000, 4'd0, 8'd0, 1'b0, 4'b1000, 4'd1);
        add(3'b000, 4'd0, 8'd0, 1'b1, 4'b1000, 4'd1);
        add(3'b000, 4'd0, 8'd0, 1'b1, 4'b1000, 4'd2);
        add(3'b000, 4'd0, 8'd0, 1'b0, 4'b1000, 4'd3);
        add(3'b000, 4'd0, 8'd0, 1'b1, 4'b1000, 4'd3);
        add(3'b000, 4'd0, 8'd0, 1'b0, 4'b0110, 4'd4);
        add(3'b000, 4'd0, 8'd0, 1'b0, 4'b0000, 4'd4);
        // Window expiry: thr=5, win=3
        add(3'b001, 4'd5, 8'd3, 1'b0, 4'b0000, 4'd4);
        add(3'b100, 4'd0, 8'd0, 1'b0, 4'b0000, 4'd4);
        add(3'b000, 4'd0, 8'd0, 1'b1, 4'b1000, 4'd0);
        add(3'b000, 4'd0, 8'd0, 1'b1, 4'b1000, 4'd1);
        add(3'b000, 4'd0, 8'd0, 1'b1, 4'b1000, 4'd2);
        add(3'b000, 4'd0, 8'd0, 1'b0, 4'b0101, 4'd3);
        add(3'b000, 4'd0, 8'd0, 1'b0, 4'b0000, 4'd3);
        // Hit and expiry together: thr=2, win=2 -> hit wins
        add(3'b001, 4'd2, 8'd2, 1'b0, 4'b0000, 4'd3);
        add(3'b100, 4'd0, 8'd0, 1'b0, 4'b0000, 4'd3);
        add(3'b000, 4'd0, 8'd0, 1'b1, 4'b1000, 4'd0);
        add(3'b000, 4'd0, 8'd0, 1'b1, 4'b1000, 4'd1);
        add(3'b000, 4'd0, 8'd0, 1'b0, 4'b0110, 4'd2);
        // Abort with data=1, config write ignored while counting
        add(3'b001, 4'd5, 8'd0, 1'b0, 4'b0000, 4'd2);
        add(3'b100, 4'd0, 8'd0, 1'b0, 4'b0000, 4'd2);
        add(3'b001, 4'd1, 8'd1, 1'b1, 4'b1000, 4'd0);
        add(3'b000, 4'd0, 8'd0, 1'b1, 4'b1000, 4'd1);
        add(3'b010, 4'd0, 8'd0, 1'b1, 4'b1000, 4'd2);
        add(3'b000, 4'd0, 8'd0, 1'b0, 4'b0000, 4'd2);
        add(3'b000, 4'd0, 8'd0, 1'b0, 4'b0000, 4'd2);
        // Config still thr=5: five ones needed, then back-to-back start in DONE
        add(3'b100, 4'd0, 8'd0, 1'b0, 4'b0000, 4'd2);
        add(3'b000, 4'd0, 8'd0, 1'b1, 4'b1000, 4'd0);
        add(3'b000, 4'd0, 8'd0, 1'b1, 4'b1000, 4'd1);
        add(3'b000, 4'd0, 8'd0, 1'b1, 4'b1000, 4'd2);
        add(3'b000, 4'd0, 8'd0, 1'b1, 4'b1000, 4'd3);
        add(3'b000, 4'd0, 8'd0, 1'b1, 4'b1000, 4'd4);
        add(3'b100, 4'd0, 8'd0, 1'b0, 4'b0110, 4'd5);
        add(3'b000, 4'd0, 8'd0, 1'b1, 4'b1000, 4'd0);
        add(3'b000, 4'd0, 8'd0, 1'b1, 4'b1000, 4'd1);
        add(3'b000, 4'd0, 8'd0, 1'b1, 4'b1000, 4'd2);
        add(3'b000, 4'd0, 8'd0, 1'b1, 4'b1000, 4'd3);
        add(3'b000, 4'd0, 8'd0, 1'b1, 4'b1000, 4'd4);
        add(3'b000, 4'd0, 8'd0, 1'b0, 4'b0110, 4'd5);
        // thr=0 behaves as 1: minimum-length jobs, back-to-back
        add(3'b001, 4'd0, 8'd0, 1'b0, 4'b0000, 4'd5);
        add(3'b100, 4'd0, 8'd0, 1'b0, 4'b0000, 4'd5);
        add(3'b000, 4'd0, 8'd0, 1'b1, 4'b1000, 4'd0);
        add(3'b100, 4'd0, 8'd0, 1'b0, 4'b0110, 4'd1);
        add(3'b000, 4'd0, 8'd0, 1'b0, 4'b1000, 4'd0);
        add(3'b000, 4'd0, 8'd0, 1'b0, 4'b1000, 4'd0);
        add(3'b000, 4'd0, 8'd0, 1'b1, 4'b1000, 4'd0);
        add(3'b000, 4'd0, 8'd0, 1'b0, 4'b0110, 4'd1);
        add(3'b000, 4'd0, 8'd0, 1'b0, 4'b0000, 4'd1);

        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            tick_check($sformatf("vec%0d", i), vecs[i].exp);
            bus.start      = vecs[i].start;
            bus.abort      = vecs[i].abort;
            bus.cfg_we     = vecs[i].cfg_we;
            bus.cfg_thresh = vecs[i].thr;
            bus.cfg_window = vecs[i].win;
            bus.data       = vecs[i].data;
        end

        // Reset in the middle of a job restores thr=4 and unlimited window
        tick_check("cfg_idle", 8'h01);
        bus.cfg_we = 1'b1; bus.cfg_thresh = 4'd3; bus.cfg_window = 8'd5;
        tick_check("cfg_written", 8'h01);
        bus.cfg_we = 1'b0; bus.start = 1'b1;
        tick_check("mid_c1", 8'h80);
        bus.start = 1'b0; bus.data = 1'b1;
        tick_check("mid_c2", 8'h81);
        tick_check("mid_c3", 8'h82);
        rst = 1'b1;
        tick_check("rst_outputs", 8'h00);
        rst = 1'b0; bus.data = 1'b0; bus.start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick_check($sformatf("no_window_%0d", i), 8'h80);
            bus.start = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            tick_check($sformatf("def_thr_%0d", i), {4'b1000, 4'(i)});
            bus.data = 1'b1;
        end
        tick_check("def_thr_hit", 8'h64);
        bus.data = 1'b0;
        tick_check("def_thr_idle", 8'h04);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
